// File: rtl/paper_float_pkg.sv
// Shared float-word definitions for the paper_float blocks: word width helper,
// the default fp16-shaped word type and the positive-zero constant.
package paper_float_pkg;

    localparam int DEF_EXP  = 5;
    localparam int DEF_FRAC = 10;

    function automatic int word_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    localparam int DEF_W = word_width(DEF_EXP, DEF_FRAC);

    typedef logic [DEF_W-1:0] float_word_t;

    localparam float_word_t FLOAT_ZERO = '0;

endpackage

// File: rtl/paper_float_out_buf.sv
// One-entry result register with a valid/ready handshake; holds the dot-product
// sum, its term count and the count-saturated flag until consumed.
module paper_float_out_buf
    import paper_float_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 load,
    input  logic                 ready,
    input  logic [W-1:0]         load_data,
    input  logic [CNT_WIDTH-1:0] load_count,
    input  logic                 load_sat,
    output logic                 valid,
    output logic [W-1:0]         data,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sat
);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else if (load) begin
            // A reload in the same cycle as a drain keeps the buffer full.
            valid <= 1'b1;
            data  <= load_data;
            count <= load_count;
            sat   <= load_sat;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/paper_float_dot_seq.sv
// Sequential dot-product controller wrapped around a combinational float MAC PE:
// feeds the PE result back as the next addend and buffers each vector's sum.
module paper_float_dot_seq
    import paper_float_pkg::*;
#(
    parameter int EXP       = 5,
    parameter int FRAC      = 10,
    parameter int CNT_WIDTH = 8,
    localparam int W        = word_width(EXP, FRAC)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [W-1:0]         inA,
    input  logic [W-1:0]         inB,
    input  logic                 inLast,
    output logic [W-1:0]         peA,
    output logic [W-1:0]         peB,
    output logic [W-1:0]         peC,
    input  logic [W-1:0]         peZ,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [W-1:0]         outData,
    output logic [CNT_WIDTH-1:0] outCount,
    output logic                 outSat
);

    typedef enum logic {EMPTY, ACCUM} state_t;

    localparam logic [W-1:0] ZERO_WORD = W'(FLOAT_ZERO);

    state_t               state;
    logic [W-1:0]         acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sat;

    logic                 accept;
    logic                 cnt_full;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 sat_next;

    assign peA = inA;
    assign peB = inB;
    assign peC = (state == ACCUM) ? acc : ZERO_WORD;

    // Backpressure is applied to every beat so a full, undrained buffer can
    // never be overwritten by a last beat arriving mid-stream.
    assign inReady = resetn & ~clear & (~outValid | outReady);
    assign accept  = inValid & inReady;

    assign cnt_full = &cnt;
    assign cnt_next = cnt_full ? cnt : cnt + 1'b1;
    assign sat_next = sat | cnt_full;

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            state <= EMPTY;
            acc   <= ZERO_WORD;
            cnt   <= '0;
            sat   <= 1'b0;
        end else if (accept) begin
            if (inLast) begin
                state <= EMPTY;
                acc   <= ZERO_WORD;
                cnt   <= '0;
                sat   <= 1'b0;
            end else begin
                state <= ACCUM;
                acc   <= peZ;
                cnt   <= cnt_next;
                sat   <= sat_next;
            end
        end
    end

    paper_float_out_buf #(
        .W         (W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_out_buf (
        .clock      (clock),
        .resetn     (resetn),
        .load       (accept & inLast),
        .ready      (outReady),
        .load_data  (peZ),
        .load_count (cnt_next),
        .load_sat   (sat_next),
        .valid      (outValid),
        .data       (outData),
        .count      (outCount),
        .sat        (outSat)
    );

endmodule
